// File: rtl/mips_mc_ctrl_pkg.sv
// mips_mc_ctrl_pkg
// Shared definitions for the multi-cycle MIPS main control FSM: opcodes,
// state encodings, ALUOp codes and the alu_src_b / pc_source mux codes.
// The ALU control stage and the datapath decode the same mux codes.
// Optional feature macro: MC_CTRL_ADDI_EN (adds the addi instruction).
package mips_mc_ctrl_pkg;

   localparam int OPCODE_W_DEF = 6;
   localparam int ALUOP_W_DEF  = 2;
   localparam int STATE_W_DEF  = 4;

`ifdef MC_CTRL_ADDI_EN
   localparam bit ADDI_EN = 1'b1;
`else
   localparam bit ADDI_EN = 1'b0;
`endif

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   // ALUOp toward ALU control
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // alu_src_b mux codes
   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   // pc_source mux codes
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Architectural state encodings (visible on state_o)
   typedef enum logic [3:0] {
      S_RESET    = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_EXEC     = 4'd7,
      S_R_WB     = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_ADDI_EX  = 4'd11,
      S_ADDI_WB  = 4'd12
   } state_t;

   // True for every opcode this build knows how to sequence.
   function automatic logic op_supported(input logic [5:0] op);
      logic ok;
      ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J)  ||
           ((op == OP_ADDI) && ADDI_EN);
      return ok;
   endfunction

endpackage

// File: rtl/mips_mc_ctrl_decode.sv
// mips_mc_ctrl_decode
// Combinational output decode for the multi-cycle control FSM.
// Inputs : state (current state code), opcode (IR[31:26]), mem_ready.
// Outputs: all datapath enables / mux selects, alu_op, instr_done, illegal_op.
// Every output is a function of state alone, except ir_write/pc_write in
// FETCH, instr_done in MEM_WR (both follow mem_ready) and illegal_op in
// DECODE (follows opcode). Unlisted and unbuilt states drive all zeros.
// Optional feature macro: MC_CTRL_ADDI_EN (ADDI_EX / ADDI_WB decode).
module mips_mc_ctrl_decode
   import mips_mc_ctrl_pkg::*;
#(
   parameter int OPCODE_W = OPCODE_W_DEF,
   parameter int ALUOP_W  = ALUOP_W_DEF,
   parameter int STATE_W  = STATE_W_DEF
) (
   input  logic [STATE_W-1:0]  state,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                i_or_d,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic                mem_to_reg,
   output logic                reg_dst,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          pc_source,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic                instr_done,
   output logic                illegal_op
);

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_B;
      pc_source     = PCSRC_ALU;
      alu_op        = ALUOP_W'(ALUOP_ADD);
      instr_done    = 1'b0;
      illegal_op    = 1'b0;

      case (state_t'(state))
         S_FETCH: begin
            // PC+4 computed every fetch cycle; IR and PC only load once
            // memory returns the word.
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            alu_op    = ALUOP_W'(ALUOP_ADD);
            pc_source = PCSRC_ALU;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            // Speculative branch target into ALUOut.
            alu_src_a  = 1'b0;
            alu_src_b  = SRCB_IMM_SH;
            alu_op     = ALUOP_W'(ALUOP_ADD);
            illegal_op = !op_supported(6'(opcode));
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_W'(ALUOP_ADD);
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            reg_dst    = 1'b0;
            instr_done = 1'b1;
         end
         S_MEM_WR: begin
            mem_write  = 1'b1;
            i_or_d     = 1'b1;
            instr_done = mem_ready;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_B;
            alu_op    = ALUOP_W'(ALUOP_FUNCT);
         end
         S_R_WB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            mem_to_reg = 1'b0;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_src_b     = SRCB_B;
            alu_op        = ALUOP_W'(ALUOP_SUB);
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
            instr_done    = 1'b1;
         end
         S_JUMP: begin
            pc_write   = 1'b1;
            pc_source  = PCSRC_JUMP;
            instr_done = 1'b1;
         end
`ifdef MC_CTRL_ADDI_EN
         S_ADDI_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_W'(ALUOP_ADD);
         end
         S_ADDI_WB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            instr_done = 1'b1;
         end
`endif
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl
// Multi-cycle main control FSM for the MIPS core. Sequences
// fetch / decode / execute / memory / writeback from the IR opcode and
// drives the datapath enables plus the 2-bit ALUOp for ALU control.
// Ports:
//   clk, rst_n (async, active-low)
//   opcode     IR[31:26], stable from DECODE to the end of the instruction
//   mem_ready  memory completes the current access this cycle
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
//   alu_op      datapath controls
//   instr_done  pulse in the final cycle of each instruction
//   illegal_op  pulse in DECODE on an unsupported opcode
//   state_o     current state (debug)
// Handshake: a memory access state (FETCH, MEM_RD, MEM_WR) holds its
// request asserted and stays put until mem_ready is sampled high on a
// rising edge; the access completes in that cycle.
// Optional feature macro: MC_CTRL_ADDI_EN (adds addi: ADDI_EX -> ADDI_WB).
// Outputs are decoded combinationally from the state register so that an
// asynchronous reset zeroes them in the same cycle.
module mips_mc_ctrl
   import mips_mc_ctrl_pkg::*;
#(
   parameter int OPCODE_W = OPCODE_W_DEF,
   parameter int ALUOP_W  = ALUOP_W_DEF,
   parameter int STATE_W  = STATE_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                i_or_d,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic                mem_to_reg,
   output logic                reg_dst,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          pc_source,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic                instr_done,
   output logic                illegal_op,
   output logic [STATE_W-1:0]  state_o
);

   state_t state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_RESET;
      end else begin
         case (state)
            S_RESET:  state <= S_FETCH;
            S_FETCH:  if (mem_ready) state <= S_DECODE;
            S_DECODE: begin
               if (opcode == OPCODE_W'(OP_RTYPE))
                  state <= S_EXEC;
               else if ((opcode == OPCODE_W'(OP_LW)) || (opcode == OPCODE_W'(OP_SW)))
                  state <= S_MEM_ADDR;
               else if (opcode == OPCODE_W'(OP_BEQ))
                  state <= S_BRANCH;
               else if (opcode == OPCODE_W'(OP_J))
                  state <= S_JUMP;
`ifdef MC_CTRL_ADDI_EN
               else if (opcode == OPCODE_W'(OP_ADDI))
                  state <= S_ADDI_EX;
`endif
               else
                  state <= S_FETCH;  // illegal: abandon, no instr_done
            end
            // Only lw/sw reach MEM_ADDR, so anything other than lw is sw.
            S_MEM_ADDR: state <= (opcode == OPCODE_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state <= S_MEM_WB;
            S_MEM_WR:   if (mem_ready) state <= S_FETCH;
            S_EXEC:     state <= S_R_WB;
`ifdef MC_CTRL_ADDI_EN
            S_ADDI_EX:  state <= S_ADDI_WB;
`endif
            // Writeback/branch/jump states, plus any unused or unbuilt
            // encoding, return to FETCH.
            default:    state <= S_FETCH;
         endcase
      end
   end

   assign state_o = STATE_W'(state);

   mips_mc_ctrl_decode #(
      .OPCODE_W (OPCODE_W),
      .ALUOP_W  (ALUOP_W),
      .STATE_W  (STATE_W)
   ) u_decode (
      .state         (STATE_W'(state)),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .mem_to_reg    (mem_to_reg),
      .reg_dst       (reg_dst),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .pc_source     (pc_source),
      .alu_op        (alu_op),
      .instr_done    (instr_done),
      .illegal_op    (illegal_op)
   );

endmodule
